// File: rtl/dma_pkg.sv
// Shared definitions for the data-memory block-copy DMA: state encoding and
// default bus widths.
package dma_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } dma_state_e;

endpackage

// File: rtl/dmem_copy_dma_if.sv
// Data-memory initiator port of the copy DMA, including the arbiter request/grant pair.
interface dmem_copy_dma_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  // bus_req/bus_gnt: the DMA raises bus_req and keeps it high while it wants the
  // bus; a transfer step starts only after an edge that sampled bus_gnt=1, and the
  // grant is only re-examined at word boundaries (end of a write).
  logic              bus_req;
  logic              bus_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_read;
  logic              mem_write;
  logic              mem_device_access;

  modport master (
    output bus_req, mem_addr, mem_wdata, mem_read, mem_write, mem_device_access,
    input  bus_gnt, mem_rdata
  );

  modport slave (
    input  bus_req, mem_addr, mem_wdata, mem_read, mem_write, mem_device_access,
    output bus_gnt, mem_rdata
  );

endinterface

// File: rtl/dmem_copy_dma.sv
// Forward block-copy engine on the data-memory port: one read cycle then one
// write cycle per word, with bus ownership requested from an external arbiter.
module dmem_copy_dma
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ADDR_W:0]     remaining,
  output logic [2:0]          dbg_state,
  dmem_copy_dma_if.master     bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   REM_ONE  = 1;

  dma_state_e        state, state_n;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [ADDR_W:0]   rem_q;
  logic [DATA_W-1:0] buf_q;
  logic              aborted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) state_n = (len != '0) ? REQ : DONE;
      end
      REQ: begin
        if (abort)        state_n = DONE;
        else if (bus.bus_gnt) state_n = RD;
      end
      RD: begin
        state_n = abort ? DONE : WR;
      end
      WR: begin
        // Word boundary: the only point where a revoked grant is honoured.
        if (abort || rem_q == REM_ONE) state_n = DONE;
        else if (bus.bus_gnt)          state_n = RD;
        else                           state_n = REQ;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      buf_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            src_q     <= src_addr;
            dst_q     <= dst_addr;
            rem_q     <= len;
            aborted_q <= 1'b0;
          end
        end
        REQ: begin
          if (abort) aborted_q <= 1'b1;
        end
        RD: begin
          // An aborted read never reaches WR, so its data is simply not kept.
          if (abort) aborted_q <= 1'b1;
          else       buf_q     <= bus.mem_rdata;
        end
        WR: begin
          src_q <= src_q + ADDR_ONE;
          dst_q <= dst_q + ADDR_ONE;
          rem_q <= rem_q - REM_ONE;
          if (abort) aborted_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Moore outputs only: nothing on the bus depends combinationally on inputs.
  always_comb begin
    bus.bus_req           = 1'b0;
    bus.mem_addr          = '0;
    bus.mem_wdata         = '0;
    bus.mem_read          = 1'b0;
    bus.mem_write         = 1'b0;
    bus.mem_device_access = 1'b0;
    busy                  = 1'b0;
    done                  = 1'b0;
    unique case (state)
      REQ: begin
        bus.bus_req = 1'b1;
        busy        = 1'b1;
      end
      RD: begin
        bus.bus_req  = 1'b1;
        bus.mem_read = 1'b1;
        bus.mem_addr = src_q;
        busy         = 1'b1;
      end
      WR: begin
        bus.bus_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.mem_addr  = dst_q;
        bus.mem_wdata = buf_q;
        busy          = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign aborted   = aborted_q;
  assign remaining = rem_q;
  assign dbg_state = state;

endmodule
